vision_packet_framer: RTL and testbench

//  Frames one vision-pipeline target report into a 10-byte packet for the byte-wide async UART transmitter.

---
 rtl/vision_packet_framer.sv | 222 ++++++++++++++++++++++
 tb/tb_vision_packet_framer.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vision_packet_framer.sv
// vision_packet_framer
//   Frames one target report from the vision pipeline into a 10-byte packet
//   and feeds it, byte by byte, to a byte-wide UART transmitter through its
//   start/data/busy handshake. A single report can wait in a pending slot
//   while a packet is in flight; a pending report that gets overwritten is
//   counted in drop_count.
//
//   Packet: SYNC, seq, {7'b0,found}, xH, xL, yH, yL, areaH, areaL, chk
//   where chk makes all ten bytes sum to zero modulo 256.
//
// Ports
//   clk          system clock
//   rst          synchronous reset, active-high
//   report_valid 1-cycle strobe qualifying tgt_* fields
//   tgt_found    target present flag
//   tgt_x/tgt_y  target centre, COORD_W bits, zero-extended to 16 in packet
//   tgt_area     target pixel area
//   tx_busy      UART busy, rises the cycle after an accepted start
//   tx_start     1-cycle start pulse to the UART
//   tx_data      byte to transmit, valid while tx_start=1
//   framer_busy  packet in flight or a report pending
//   seq          sequence number of the most recently loaded packet
//   drop_count   reports lost to overwrite, saturating at 255
module vision_packet_framer #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned COORD_W   = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               report_valid,
  input  logic               tgt_found,
  input  logic [COORD_W-1:0] tgt_x,
  input  logic [COORD_W-1:0] tgt_y,
  input  logic [15:0]        tgt_area,
  input  logic               tx_busy,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  output logic               framer_busy,
  output logic [7:0]         seq,
  output logic [7:0]         drop_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_WAIT
  } state_e;

  state_e state_q, state_d;
  logic [3:0] idx_q, idx_d;

  // Active report: the fields of the packet currently on the wire.
  logic               act_found_q;
  logic [COORD_W-1:0] act_x_q, act_y_q;
  logic [15:0]        act_area_q;

  // One-deep pending slot.
  logic               pend_valid_q, pend_valid_d;
  logic               pend_found_q;
  logic [COORD_W-1:0] pend_x_q, pend_y_q;
  logic [15:0]        pend_area_q;

  logic [7:0] seq_q;
  logic [7:0] drop_q;

  // Datapath controls produced by the next-state logic.
  logic load_rpt;   // incoming report straight to active
  logic load_pend;  // pending slot to active
  logic wr_pend;    // incoming report into pending slot
  logic drop_inc;   // a valid pending report is being overwritten

  logic [15:0] x16, y16;
  logic [7:0]  sum8, chk, cur_byte;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    load_rpt  = 1'b0;
    load_pend = 1'b0;
    wr_pend   = 1'b0;
    drop_inc  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (report_valid) begin
          load_rpt = 1'b1;
          idx_d    = '0;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (!tx_busy) state_d = ST_GAP;
      end
      ST_GAP: begin
        // UART busy is still settling here, so it is not looked at.
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!tx_busy) begin
          if (idx_q != 4'd9) begin
            idx_d   = idx_q + 4'd1;
            state_d = ST_SEND;
          end else begin
            idx_d = '0;
            if (pend_valid_q) begin
              load_pend = 1'b1;
              state_d   = ST_SEND;
            end else if (report_valid) begin
              load_rpt = 1'b1;
              state_d  = ST_SEND;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A report not consumed directly goes to the pending slot. When the
    // pending slot is emptied into active in the same cycle, the old pending
    // report is not lost, so no drop is counted.
    if (report_valid && (state_q != ST_IDLE) && !load_rpt) begin
      wr_pend  = 1'b1;
      drop_inc = pend_valid_q && !load_pend;
    end

    if (wr_pend)        pend_valid_d = 1'b1;
    else if (load_pend) pend_valid_d = 1'b0;
    else                pend_valid_d = pend_valid_q;
  end

  // Output logic
  always_comb begin
    tx_start    = 1'b0;
    tx_data     = '0;
    framer_busy = (state_q != ST_IDLE) || pend_valid_q;
    if (state_q == ST_SEND) begin
      tx_start = !tx_busy;
      tx_data  = cur_byte;
    end
  end

  assign seq        = seq_q;
  assign drop_count = drop_q;

  // Report datapath: active/pending capture, sequence and drop counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_found_q  <= 1'b0;
      act_x_q      <= '0;
      act_y_q      <= '0;
      act_area_q   <= '0;
      pend_valid_q <= 1'b0;
      pend_found_q <= 1'b0;
      pend_x_q     <= '0;
      pend_y_q     <= '0;
      pend_area_q  <= '0;
      seq_q        <= 8'hFF;
      drop_q       <= '0;
    end else begin
      if (load_rpt) begin
        act_found_q <= tgt_found;
        act_x_q     <= tgt_x;
        act_y_q     <= tgt_y;
        act_area_q  <= tgt_area;
        seq_q       <= seq_q + 8'd1;
      end else if (load_pend) begin
        act_found_q <= pend_found_q;
        act_x_q     <= pend_x_q;
        act_y_q     <= pend_y_q;
        act_area_q  <= pend_area_q;
        seq_q       <= seq_q + 8'd1;
      end
      if (wr_pend) begin
        pend_found_q <= tgt_found;
        pend_x_q     <= tgt_x;
        pend_y_q     <= tgt_y;
        pend_area_q  <= tgt_area;
      end
      pend_valid_q <= pend_valid_d;
      if (drop_inc && (drop_q != 8'hFF)) drop_q <= drop_q + 8'd1;
    end
  end

  // Packet byte selection; checksum is formed from the active registers.
  always_comb begin
    x16  = 16'(act_x_q);
    y16  = 16'(act_y_q);
    sum8 = SYNC_BYTE + seq_q + {7'd0, act_found_q}
         + x16[15:8] + x16[7:0] + y16[15:8] + y16[7:0]
         + act_area_q[15:8] + act_area_q[7:0];
    chk  = 8'd0 - sum8;
    case (idx_q)
      4'd0:    cur_byte = SYNC_BYTE;
      4'd1:    cur_byte = seq_q;
      4'd2:    cur_byte = {7'd0, act_found_q};
      4'd3:    cur_byte = x16[15:8];
      4'd4:    cur_byte = x16[7:0];
      4'd5:    cur_byte = y16[15:8];
      4'd6:    cur_byte = y16[7:0];
      4'd7:    cur_byte = act_area_q[15:8];
      4'd8:    cur_byte = act_area_q[7:0];
      4'd9:    cur_byte = chk;
      default: cur_byte = '0;
    endcase
  end

endmodule

// File: tb/tb_vision_packet_framer.sv
module tb_vision_packet_framer;
  localparam int unsigned CW   = 10;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic          clk          = 1'b0;
  logic          rst          = 1'b1;
  logic          report_valid = 1'b0;
  logic          tgt_found    = 1'b0;
  logic [CW-1:0] tgt_x        = '0;
  logic [CW-1:0] tgt_y        = '0;
  logic [15:0]   tgt_area     = '0;
  logic          tx_busy      = 1'b0;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          framer_busy;
  logic [7:0]    seq;
  logic [7:0]    drop_count;

  vision_packet_framer #(.SYNC_BYTE(SYNC), .COORD_W(CW)) dut (
    .clk(clk), .rst(rst), .report_valid(report_valid),
    .tgt_found(tgt_found), .tgt_x(tgt_x), .tgt_y(tgt_y), .tgt_area(tgt_area),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .framer_busy(framer_busy), .seq(seq), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // UART stub: busy rises the cycle after an accepted start and stays high
  // for a length drawn from [busy_min, busy_max].
  int unsigned busy_min   = 2;
  int unsigned busy_max   = 2;
  int unsigned busy_cnt   = 0;
  logic        start_seen = 1'b0;
  always @(posedge clk) begin
    #1;
    if (start_seen === 1'b1) begin
      tx_busy  = 1'b1;
      busy_cnt = $urandom_range(busy_max, busy_min) - 1;
    end else if (tx_busy) begin
      if (busy_cnt == 0) tx_busy = 1'b0;
      else busy_cnt = busy_cnt - 1;
    end
  end

  // Reference model: packets as byte lists, a one-slot pending report.
  bit          mon_en    = 1'b0;
  bit          in_flight = 1'b0;
  bit          gap       = 1'b0;
  bit          pend_v    = 1'b0;
  bit          need_busy = 1'b0;
  int unsigned sent        = 0;
  int unsigned start_cnt   = 0;
  int unsigned pkt_cnt     = 0;
  int unsigned collide_cnt = 0;
  logic [7:0]  seq_m  = 8'hFF;
  logic [7:0]  drop_m = 8'h00;
  logic [7:0]  cur [10];
  logic [7:0]  obs [10];
  logic          pf;
  logic [CW-1:0] px, py;
  logic [15:0]   pa;
  logic [7:0]  log_q [$];

  task automatic load_pkt(input logic f, input logic [CW-1:0] x,
                          input logic [CW-1:0] y, input logic [15:0] a);
    logic [15:0] x16, y16;
    logic [7:0]  s;
    seq_m  = seq_m + 8'd1;
    x16    = 16'(x);
    y16    = 16'(y);
    cur[0] = SYNC;       cur[1] = seq_m;      cur[2] = {7'd0, f};
    cur[3] = x16[15:8];  cur[4] = x16[7:0];
    cur[5] = y16[15:8];  cur[6] = y16[7:0];
    cur[7] = a[15:8];    cur[8] = a[7:0];
    s = 8'd0;
    for (int i = 0; i < 9; i++) s = s + cur[i];
    cur[9]    = 8'd0 - s;
    sent      = 0;
    in_flight = 1'b1;
  endtask

  always @(negedge clk) begin : monitor
    bit         done_now;
    logic [7:0] psum;
    start_seen = tx_start;
    if (mon_en) begin
      checks++;
      if (framer_busy !== (in_flight || pend_v)) begin
        failures++;
        $display("FAIL framer_busy got=%b exp=%b t=%0t", framer_busy, in_flight || pend_v, $time);
      end
      checks++;
      if (seq !== seq_m) begin
        failures++;
        $display("FAIL seq got=%0h exp=%0h t=%0t", seq, seq_m, $time);
      end
      checks++;
      if (drop_count !== drop_m) begin
        failures++;
        $display("FAIL drop_count got=%0d exp=%0d t=%0t", drop_count, drop_m, $time);
      end
      checks++;
      if (tx_start === 1'b1) begin
        if (tx_busy !== 1'b0 || need_busy || !in_flight || sent >= 10 || gap) begin
          failures++;
          $display("FAIL start_rule got=start busy=%b need_busy=%b in_flight=%b sent=%0d gap=%b exp=no_start t=%0t",
                   tx_busy, need_busy, in_flight, sent, gap, $time);
        end
        if (sent < 10) begin
          checks++;
          if (tx_data !== cur[sent]) begin
            failures++;
            $display("FAIL tx_data[%0d] got=%0h exp=%0h t=%0t", sent, tx_data, cur[sent], $time);
          end
          obs[sent] = tx_data;
        end
        log_q.push_back(tx_data);
        start_cnt++;
      end else if (tx_start !== 1'b0) begin
        failures++;
        $display("FAIL tx_start_known got=%b exp=0/1 t=%0t", tx_start, $time);
      end

      if (tx_busy === 1'b1) need_busy = 1'b0;

      if (rst === 1'b1) begin
        in_flight = 1'b0; pend_v = 1'b0; sent = 0; gap = 1'b0;
        seq_m = 8'hFF; drop_m = 8'h00;
      end else begin
        done_now = in_flight && sent == 10 && tx_busy === 1'b0 && !gap;
        if (tx_start === 1'b1 && in_flight && sent < 10) sent++;
        if (done_now) begin
          psum = 8'd0;
          for (int i = 0; i < 10; i++) psum = psum + obs[i];
          checks++;
          if (psum !== 8'd0) begin
            failures++;
            $display("FAIL pkt_sum got=%0h exp=00 t=%0t", psum, $time);
          end
          pkt_cnt++;
        end
        if (report_valid === 1'b1) begin
          if (!in_flight) begin
            load_pkt(tgt_found, tgt_x, tgt_y, tgt_area);
          end else if (done_now) begin
            collide_cnt++;
            if (pend_v) begin
              load_pkt(pf, px, py, pa);
              pf = tgt_found; px = tgt_x; py = tgt_y; pa = tgt_area;
            end else begin
              load_pkt(tgt_found, tgt_x, tgt_y, tgt_area);
            end
          end else begin
            if (pend_v && drop_m != 8'hFF) drop_m = drop_m + 8'd1;
            pf = tgt_found; px = tgt_x; py = tgt_y; pa = tgt_area;
            pend_v = 1'b1;
          end
        end else if (done_now) begin
          if (pend_v) begin
            load_pkt(pf, px, py, pa);
            pend_v = 1'b0;
          end else begin
            in_flight = 1'b0;
          end
        end
        gap = (tx_start === 1'b1);
      end
      if (tx_start === 1'b1) need_busy = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] log_at(input int i);
    if (i < log_q.size()) return log_q[i];
    return 8'hxx;
  endfunction

  task automatic drive_report(input logic f, input logic [CW-1:0] x,
                              input logic [CW-1:0] y, input logic [15:0] a);
    tgt_found = f; tgt_x = x; tgt_y = y; tgt_area = a;
    report_valid = 1'b1;
    tick();
    report_valid = 1'b0;
    // Scramble the fields so late capture would corrupt the packet.
    tgt_found = 1'($urandom); tgt_x = 10'($urandom); tgt_y = 10'($urandom);
    tgt_area = 16'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int i = 0;
    while (!(framer_busy === 1'b0 && tx_busy === 1'b0) && i < limit) begin
      tick();
      i++;
    end
    checks++;
    if (!(framer_busy === 1'b0 && tx_busy === 1'b0)) begin
      failures++;
      $display("FAIL wait_idle got=busy exp=idle within %0d cycles", limit);
    end
  endtask

  task automatic wait_bytes(input int n, input int limit);
    int i = 0;
    while (log_q.size() < n && i < limit) begin
      tick();
      i++;
    end
    checks++;
    if (log_q.size() < n) begin
      failures++;
      $display("FAIL wait_bytes got=%0d exp=%0d", log_q.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if (tx_start !== 1'b0) begin failures++; $display("FAIL rst_tx_start got=%b exp=0", tx_start); end
    checks++;
    if (tx_data !== 8'h00) begin failures++; $display("FAIL rst_tx_data got=%0h exp=00", tx_data); end
    checks++;
    if (framer_busy !== 1'b0) begin failures++; $display("FAIL rst_framer_busy got=%b exp=0", framer_busy); end
    checks++;
    if (seq !== 8'hFF) begin failures++; $display("FAIL rst_seq got=%0h exp=ff", seq); end
    checks++;
    if (drop_count !== 8'h00) begin failures++; $display("FAIL rst_drop got=%0d exp=0", drop_count); end
    mon_en = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] exp_b [10];
    exp_b = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h23, 8'h00, 8'h45, 8'h08, 8'h00, 8'hE9};
    busy_min = 12; busy_max = 12;
    log_q.delete();
    start_cnt = 0;
    drive_report(1'b1, 10'h123, 10'h045, 16'h0800);
    checks++;
    if (tx_start !== 1'b1 || tx_data !== SYNC) begin
      failures++;
      $display("FAIL latency got=start:%b data:%0h exp=start:1 data:a5", tx_start, tx_data);
    end
    wait_idle(2000);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (log_at(i) !== exp_b[i]) begin
        failures++;
        $display("FAIL basic_byte[%0d] got=%0h exp=%0h", i, log_at(i), exp_b[i]);
      end
    end
    checks++;
    if (start_cnt != 10) begin failures++; $display("FAIL basic_starts got=%0d exp=10", start_cnt); end
    checks++;
    if (seq !== 8'h00) begin failures++; $display("FAIL basic_seq got=%0h exp=00", seq); end
  endtask

  task automatic test_random();
    int unsigned p0;
    do_reset();
    busy_min = 1; busy_max = 4;
    p0 = pkt_cnt;
    for (int n = 0; n < 280; n++) begin
      drive_report(1'($urandom), 10'($urandom), 10'($urandom), 16'($urandom));
      wait_idle(1000);
    end
    checks++;
    if (seq !== 8'd23) begin failures++; $display("FAIL random_seq_wrap got=%0d exp=23", seq); end
    checks++;
    if (pkt_cnt - p0 != 280) begin failures++; $display("FAIL random_pkts got=%0d exp=280", pkt_cnt - p0); end
    checks++;
    if (drop_count !== 8'd0) begin failures++; $display("FAIL random_drop got=%0d exp=0", drop_count); end
  endtask

  task automatic test_overwrite();
    bit idle_seen = 1'b0;
    int i = 0;
    do_reset();
    busy_min = 3; busy_max = 6;
    wait_idle(200);
    log_q.delete();
    drive_report(1'b1, 10'h155, 10'h2AA, 16'h1234);
    repeat (5) tick();
    drive_report(1'b0, 10'h001, 10'h002, 16'h0003);
    repeat (3) tick();
    drive_report(1'b1, 10'h3C7, 10'h0F0, 16'hBEEF);
    while (!(log_q.size() >= 20 && framer_busy === 1'b0 && tx_busy === 1'b0) && i < 3000) begin
      tick();
      if (framer_busy !== 1'b1 && log_q.size() < 20) idle_seen = 1'b1;
      i++;
    end
    checks++;
    if (log_q.size() != 20) begin failures++; $display("FAIL ovw_bytes got=%0d exp=20", log_q.size()); end
    checks++;
    if (drop_count !== 8'd1) begin failures++; $display("FAIL ovw_drop got=%0d exp=1", drop_count); end
    checks++;
    if (log_at(11) !== 8'h01) begin failures++; $display("FAIL ovw_seq got=%0h exp=01", log_at(11)); end
    checks++;
    if (log_at(13) !== 8'h03 || log_at(14) !== 8'hC7 || log_at(17) !== 8'hBE) begin
      failures++;
      $display("FAIL ovw_r2 got=%0h/%0h/%0h exp=03/c7/be", log_at(13), log_at(14), log_at(17));
    end
    checks++;
    if (idle_seen) begin failures++; $display("FAIL ovw_no_idle got=idle exp=busy"); end
  endtask

  task automatic test_done_collision();
    // Empty pending slot: report arrives the cycle the packet completes.
    do_reset();
    busy_min = 5; busy_max = 5;
    wait_idle(200);
    log_q.delete();
    collide_cnt = 0;
    drive_report(1'b0, 10'h0AA, 10'h155, 16'h00FF);
    wait_bytes(10, 1000);
    repeat (5) tick();
    drive_report(1'b1, 10'h200, 10'h3FF, 16'hA55A);
    wait_idle(1000);
    checks++;
    if (collide_cnt != 1) begin failures++; $display("FAIL col_a_hit got=%0d exp=1", collide_cnt); end
    checks++;
    if (drop_count !== 8'd0) begin failures++; $display("FAIL col_a_drop got=%0d exp=0", drop_count); end
    checks++;
    if (log_q.size() != 20 || log_at(13) !== 8'h02 || log_at(16) !== 8'hFF || log_at(18) !== 8'h5A) begin
      failures++;
      $display("FAIL col_a_pkt got=n%0d %0h/%0h/%0h exp=n20 02/ff/5a",
               log_q.size(), log_at(13), log_at(16), log_at(18));
    end

    // Valid pending slot plus a report on the completion cycle.
    do_reset();
    wait_idle(200);
    log_q.delete();
    collide_cnt = 0;
    drive_report(1'b0, 10'h0AA, 10'h155, 16'h00FF);
    repeat (4) tick();
    drive_report(1'b1, 10'h200, 10'h3FF, 16'hA55A);
    wait_bytes(10, 1000);
    repeat (5) tick();
    drive_report(1'b0, 10'h1FE, 10'h010, 16'h7F80);
    wait_idle(2000);
    checks++;
    if (collide_cnt != 1) begin failures++; $display("FAIL col_b_hit got=%0d exp=1", collide_cnt); end
    checks++;
    if (drop_count !== 8'd0) begin failures++; $display("FAIL col_b_drop got=%0d exp=0", drop_count); end
    checks++;
    if (log_q.size() != 30 || log_at(14) !== 8'h00 || log_at(24) !== 8'hFE || log_at(27) !== 8'h7F) begin
      failures++;
      $display("FAIL col_b_pkt got=n%0d %0h/%0h/%0h exp=n30 00/fe/7f",
               log_q.size(), log_at(14), log_at(24), log_at(27));
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    busy_min = 4; busy_max = 8;
    wait_idle(200);
    log_q.delete();
    drive_report(1'b1, 10'h3FF, 10'h3FF, 16'hFFFF);
    wait_bytes(5, 1000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (tx_start !== 1'b0 || tx_data !== 8'h00 || framer_busy !== 1'b0 || seq !== 8'hFF || drop_count !== 8'h00) begin
      failures++;
      $display("FAIL mid_rst_outputs got=%b/%0h/%b/%0h/%0d exp=0/00/0/ff/0",
               tx_start, tx_data, framer_busy, seq, drop_count);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (tx_start !== 1'b0) begin failures++; $display("FAIL mid_rst_quiet got=%b exp=0", tx_start); end
    end
    log_q.delete();
    drive_report(1'b0, 10'h111, 10'h222, 16'h3333);
    wait_idle(1000);
    checks++;
    if (log_q.size() != 10 || log_at(0) !== SYNC || log_at(1) !== 8'h00 || log_at(4) !== 8'h11) begin
      failures++;
      $display("FAIL mid_rst_pkt got=n%0d %0h/%0h/%0h exp=n10 a5/00/11",
               log_q.size(), log_at(0), log_at(1), log_at(4));
    end
  endtask

  task automatic test_saturate();
    do_reset();
    busy_min = 1; busy_max = 40;
    for (int i = 0; i < 600; i++) begin
      tgt_found = 1'($urandom); tgt_x = 10'($urandom); tgt_y = 10'($urandom);
      tgt_area = 16'($urandom);
      report_valid = 1'b1;
      tick();
    end
    report_valid = 1'b0;
    checks++;
    if (drop_count !== 8'hFF) begin failures++; $display("FAIL sat_drop got=%0d exp=255", drop_count); end
    wait_idle(5000);
  endtask

  task automatic test_sparse();
    int unsigned p0;
    do_reset();
    busy_min = 1; busy_max = 10;
    p0 = pkt_cnt;
    for (int i = 0; i < 3000; i++) begin
      tgt_found = 1'($urandom); tgt_x = 10'($urandom); tgt_y = 10'($urandom);
      tgt_area = 16'($urandom);
      report_valid = ($urandom_range(19, 0) == 0);
      tick();
    end
    report_valid = 1'b0;
    wait_idle(3000);
    checks++;
    if (pkt_cnt == p0) begin failures++; $display("FAIL sparse_pkts got=0 exp=>0"); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_overwrite();
    test_done_collision();
    test_reset_mid();
    test_saturate();
    test_sparse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
